// File: rtl/posit_encoder.sv
// posit_encoder
// Pipelined posit packing stage. Takes sign, total scale, normalised mantissa
// and special flags from the posit multiplier datapath and produces an N-bit
// posit. Stage 1 assembles the regime/exponent/fraction body string and makes
// the saturation decision. Stage 2 rounds, clamps and applies the sign.
//
// Configuration macro: POSIT_ENC_RNE_EN
//   defined   -> round-to-nearest-even on the guard/sticky bits
//   undefined -> truncation; saturation and minpos forcing still apply
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input fields valid
//   in_ready   encoder accepts input this cycle (combinational from out_ready)
//   in_sign    result sign
//   in_scale   signed total exponent, regime * 2^ES + exponent
//   in_mant    normalised mantissa, bit 2N-1 is the hidden one
//   in_inf     NaR operand (highest priority)
//   in_zero    zero result
//   out_valid  out_posit valid
//   out_ready  downstream accepts
//   out_posit  encoded posit word
module posit_encoder #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [ES+RS+1:0]     in_scale,
    input  logic [2*N-1:0]       in_mant,
    input  logic                 in_inf,
    input  logic                 in_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit
);

    localparam int SW = ES + RS + 2;   // scale width
    localparam int BW = 2 * N + ES;    // body register width

    localparam logic signed [SW-1:0] SAT_HI = SW'((N - 2) << ES);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        K_NORM,
        K_MAXPOS,
        K_MINPOS,
        K_NAR,
        K_ZERO
    } kind_e;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: decompose scale into regime k and exponent e, build body
    // ------------------------------------------------------------------
    logic signed [SW-1:0] k;
    logic [SW-1:0]        regime_len;
    logic [SW-1:0]        ones_cnt;
    logic [SW-1:0]        zeros_cnt;
    logic [BW-1:0]        tail_al;
    logic [BW-1:0]        regime_bits;
    logic [BW-1:0]        body_next;
    kind_e                kind_next;
    logic                 unused_hidden;

    // The hidden one is implied by the regime encoding and never stored.
    assign unused_hidden = in_mant[2*N-1];

    assign k = $signed(in_scale) >>> ES;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        regime_len  = '0;
        ones_cnt    = '0;
        zeros_cnt   = '0;
        regime_bits = '0;
        body_next   = '0;
        kind_next   = K_NORM;

        if (k[SW-1]) begin
            // k < 0: -k zeros then a terminating one
            zeros_cnt   = -k;
            regime_len  = zeros_cnt + SW'(1);
            regime_bits = {1'b1, {(BW-1){1'b0}}} >> zeros_cnt;
        end else begin
            // k >= 0: k+1 ones then a terminating zero (left as zero)
            ones_cnt    = k + SW'(1);
            regime_len  = k + SW'(2);
            regime_bits = ~({BW{1'b1}} >> ones_cnt);
        end

        // Exponent and fraction follow the regime; anything pushed past the
        // end of the body register is dropped.
        tail_al   = {in_scale[ES-1:0], in_mant[2*N-2:0], 1'b0};
        body_next = regime_bits | (tail_al >> regime_len);

        if (in_inf)                          kind_next = K_NAR;
        else if (in_zero)                    kind_next = K_ZERO;
        else if ($signed(in_scale) >= SAT_HI) kind_next = K_MAXPOS;
        else if ($signed(in_scale) <  SAT_LO) kind_next = K_MINPOS;
        else                                 kind_next = K_NORM;
    end

    logic          s1_sign;
    logic [BW-1:0] s1_body;
    kind_e         s1_kind;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too so out_posit reads 0 out of
            // reset and no stale body can leak after a mid-flight reset.
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_body  <= '0;
            s1_kind  <= K_ZERO;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_body <= body_next;
                s1_kind <= kind_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, clamp, negate
    // ------------------------------------------------------------------
    logic [N-1:0] mag_trunc;
    logic [N-1:0] mag_sum;
    logic [N-1:0] mag;
    logic [N-1:0] posit_next;
    logic         guard;
    logic         sticky;
    logic         round_up;

    assign mag_trunc = {1'b0, s1_body[BW-1 -: N-1]};
    assign guard     = s1_body[BW-N];
    assign sticky    = |s1_body[BW-N-1:0];

`ifdef POSIT_ENC_RNE_EN
    assign round_up = guard & (mag_trunc[0] | sticky);
`else
    logic unused_grs;
    assign unused_grs = guard ^ sticky;
    assign round_up   = 1'b0;
`endif

    always_comb begin
        mag_sum    = mag_trunc + N'(round_up);
        mag        = mag_sum;
        posit_next = '0;

        // Rounding can carry into the sign position; clamp back to maxpos.
        if (mag_sum[N-1])   mag = MAXPOS;
        // A nonzero value never collapses to zero.
        if (mag_sum == '0)  mag = MINPOS;

        unique case (s1_kind)
            K_MAXPOS: mag = MAXPOS;
            K_MINPOS: mag = MINPOS;
            default:  ;
        endcase

        posit_next = s1_sign ? (~mag + N'(1)) : mag;

        if (s1_kind == K_NAR)  posit_next = NAR;
        if (s1_kind == K_ZERO) posit_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_posit <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_posit <= posit_next;
            end
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder (N=8, ES=3).
// Directed table of encodings, backpressure and mid-flight reset sequences,
// then a randomized stream against an arithmetic reference model.
module tb_posit_encoder;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int SW = ES + $clog2(N) + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [SW-1:0] in_scale;
    logic [2*N-1:0] in_mant;
    logic          in_inf;
    logic          in_zero;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_posit;

    int checks   = 0;
    int failures = 0;

    posit_encoder #(.N(N), .ES(ES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_mant   (in_mant),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  scale;
        logic [15:0] mant;
        logic        inf;
        logic        zero;
        logic [7:0]  exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: build the body as a list of bits straight from the posit
    // definition, then round with integer arithmetic.
    function automatic logic [7:0] model(input logic sign, input logic [7:0] scale,
                                         input logic [15:0] mant, input logic inf,
                                         input logic zero);
        int sc;
        int e;
        int k;
        int mag;
        bit g;
        bit s;
        bit q[$];
        if (inf)  return 8'h80;
        if (zero) return 8'h00;
        sc = int'($signed(scale));
        if (sc >= 48)      mag = 127;
        else if (sc < -48) mag = 1;
        else begin
            e = sc & 7;
            k = (sc - e) / 8;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--)  q.push_back(bit'((e >> i) & 1));
            for (int i = 14; i >= 0; i--) q.push_back(mant[i]);
            while (q.size() < 19) q.push_back(1'b0);
            mag = 0;
            for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
            g = q[7];
            s = 1'b0;
            for (int i = 8; i < 19; i++) s = s | q[i];
`ifdef POSIT_ENC_RNE_EN
            if (g && ((mag % 2) == 1 || s)) mag = mag + 1;
`endif
            if (mag > 127) mag = 127;
            if (mag == 0)  mag = 1;
        end
        if (sign) return 8'((256 - mag) % 256);
        return 8'(mag);
    endfunction

    task automatic drive(input vec_t v);
        in_sign  = v.sign;
        in_scale = v.scale;
        in_mant  = v.mant;
        in_inf   = v.inf;
        in_zero  = v.zero;
    endtask

    function automatic vec_t mk(input string name, input logic sign, input logic [7:0] scale,
                                input logic [15:0] mant, input logic inf, input logic zero,
                                input logic [7:0] exp);
        vec_t v;
        v.name = name; v.sign = sign; v.scale = scale; v.mant = mant;
        v.inf = inf; v.zero = zero; v.exp = exp;
        return v;
    endfunction

    // One transaction through an otherwise idle pipeline, out_ready high.
    task automatic run_one(input vec_t v);
        bit acc;
        bit got;
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1;
            if (in_ready) acc = 1'b1;
            else @(negedge clk);
        end
        check({v.name, " accepted"}, 32'(acc), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                check(v.name, 32'(out_posit), 32'(v.exp));
            end
        end
        if (!got) check({v.name, " out_valid timeout"}, 32'd0, 32'd1);
    endtask

    vec_t vecs[$];
    vec_t bp[4];
    logic [7:0] sb[$];

    initial begin
        int sent;
        int rcvd;
        int first_out;
        int last_out;
        bit stale;
        vec_t r;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk("idle", 1'b0, 8'd0, 16'h8000, 1'b0, 1'b0, 8'h00));

        // ---------------- reset state ----------------
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_posit", 32'(out_posit), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("in_ready after reset", 32'(in_ready), 32'd1);

        // ---------------- directed table ----------------
        vecs.push_back(mk("scale0",       0, 8'd0,   16'h8000, 0, 0, 8'h40));
        vecs.push_back(mk("scale1",       0, 8'd1,   16'h8000, 0, 0, 8'h44));
        vecs.push_back(mk("scale8",       0, 8'd8,   16'h8000, 0, 0, 8'h60));
        vecs.push_back(mk("mantC000",     0, 8'd0,   16'hC000, 0, 0, 8'h42));
        vecs.push_back(mk("neg scale0",   1, 8'd0,   16'h8000, 0, 0, 8'hC0));
        vecs.push_back(mk("tie even",     0, 8'd0,   16'h9000, 0, 0, 8'h40));
`ifdef POSIT_ENC_RNE_EN
        vecs.push_back(mk("tie odd",      0, 8'd0,   16'hB000, 0, 0, 8'h42));
`else
        vecs.push_back(mk("tie odd trunc",0, 8'd0,   16'hB000, 0, 0, 8'h41));
`endif
        vecs.push_back(mk("sat 48",       0, 8'd48,  16'h8000, 0, 0, 8'h7F));
        vecs.push_back(mk("sat 100",      0, 8'd100, 16'h8000, 0, 0, 8'h7F));
        vecs.push_back(mk("sat -100",     0, 8'h9C,  16'h8000, 0, 0, 8'h01)); // -100
        vecs.push_back(mk("neg sat 100",  1, 8'd100, 16'h8000, 0, 0, 8'h81));
        vecs.push_back(mk("nar",          1, 8'd5,   16'hA000, 1, 0, 8'h80));
        vecs.push_back(mk("zero",         1, 8'd5,   16'hA000, 0, 1, 8'h00));
        vecs.push_back(mk("nar+zero",     0, 8'd0,   16'h8000, 1, 1, 8'h80));
        vecs.push_back(mk("scale -48",    0, 8'hD0,  16'h8000, 0, 0, 8'h01)); // -48
        vecs.push_back(mk("scale -8",     0, 8'hF8,  16'h8000, 0, 0, 8'h20)); // k=-1
        foreach (vecs[i]) run_one(vecs[i]);

        // ---------------- backpressure ----------------
        bp[0] = mk("bp0", 0, 8'd0,  16'h8000, 0, 0, 8'h40);
        bp[1] = mk("bp1", 0, 8'd8,  16'h8000, 0, 0, 8'h60);
        bp[2] = mk("bp2", 1, 8'd1,  16'h8000, 0, 0, 8'hBC);
        bp[3] = mk("bp3", 0, 8'd48, 16'h8000, 0, 0, 8'h7F);
        sent = 0; rcvd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (sent < 4);
            if (sent < 4) drive(bp[sent]);
            #1;
            if (out_valid) check("bp hold out_posit", 32'(out_posit), 32'h40);
            if (in_valid && in_ready) sent++;
        end
        check("bp accepted while stalled", 32'(sent), 32'd2);
        check("bp in_ready stalled", 32'(in_ready), 32'd0);
        check("bp out_valid stalled", 32'(out_valid), 32'd1);
        first_out = -1; last_out = -1;
        for (int c = 0; c < 12 && rcvd < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 4);
            if (sent < 4) drive(bp[sent]);
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("bp drain %0d", rcvd), 32'(out_posit), 32'(bp[rcvd].exp));
                if (first_out < 0) first_out = c;
                last_out = c;
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp drained count", 32'(rcvd), 32'd4);
        check("bp back-to-back span", 32'(last_out - first_out), 32'd3);
        @(negedge clk) in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- reset mid-flight ----------------
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (sent < 2);
            if (sent < 2) drive(bp[sent + 1]);
            #1;
            if (in_valid && in_ready) sent++;
        end
        check("rst flight out_valid before", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst async out_valid", 32'(out_valid), 32'd0);
        check("rst async out_posit", 32'(out_posit), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("rst in_ready after release", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("rst no stale result", 32'(stale), 32'd0);

        // ---------------- randomized stream ----------------
        for (int c = 0; c < 600; c++) begin
            int v;
            @(negedge clk);
            r.sign = 1'($urandom);
            if ($urandom_range(0, 3) == 0) r.scale = 8'($urandom);
            else begin
                v = int'($urandom_range(0, 112)) - 56;
                r.scale = 8'(v);
            end
            r.mant  = {1'b1, 15'($urandom)};
            r.inf   = ($urandom_range(0, 15) == 0);
            r.zero  = ($urandom_range(0, 15) == 0);
            drive(r);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("rnd spurious output", 32'(out_posit), 32'hFFFF_FFFF);
                else check($sformatf("rnd cyc%0d s%0h", c, r.scale), 32'(out_posit), 32'(sb.pop_front()));
            end
            if (in_valid && in_ready) sb.push_back(model(r.sign, r.scale, r.mant, r.inf, r.zero));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (sb.size() == 0) check("rnd drain spurious", 32'(out_posit), 32'hFFFF_FFFF);
                else check("rnd drain", 32'(out_posit), 32'(sb.pop_front()));
            end
        end
        check("rnd scoreboard empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
